majority_input: RTL and testbench
=================================

Name: majority_input

Overview:
- Registered N-input majority voter; default is a 7-input vote.
- Counts the set bits of a sampled input vector and drives `out` high when the count reaches the majority threshold.
- Used as a voting/decision primitive (redundant-signal voting, filter decision) in the datapath.
- One clock domain; result is registered, so latency is fixed at one cycle.

Parameters:
- WIDTH, 7, number of voting inputs; legal range 1..64.
- THRESHOLD, (WIDTH/2)+1, minimum number of ones that produces `out`=1; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies `in`; a sample is taken only when in_valid=1.
- in  input  WIDTH  vote vector; bit i is voter i.
- out  output  1  registered majority result.
- out_valid  output  1  high for one cycle, the cycle after an accepted sample.

Behaviour:
- Reset:
  - rst_n low asynchronously clears out=0 and out_valid=0 (and ones_count=0 when the optional feature is built in).
  - Release is synchronous to clk; the first sample is accepted on the first rising edge with rst_n=1.
- Count and vote (combinational): count = number of ones in `in`, width $clog2(WIDTH+1); vote = (count >= THRESHOLD).
- Sampling, at each rising clk with rst_n=1:
  - in_valid=1 → out <= vote, out_valid <= 1.
  - in_valid=0 → out holds its last value, out_valid <= 0.
- Latency: exactly one cycle from the accepting edge to out/out_valid. Back-to-back valid inputs give one result per cycle. No backpressure.
- Ties: for even WIDTH with the default THRESHOLD, an exact half count gives out=0 (strict majority).
- Boundaries:
  - All zeros → 0.
  - All ones → 1.
  - count = THRESHOLD-1 → 0.
  - count = THRESHOLD → 1.
- Reset mid-stream: out_valid drops immediately; no pending result survives reset.
- X/Z on `in` while in_valid=0 must not disturb out.
- Elaboration check: THRESHOLD outside 1..WIDTH, or WIDTH outside 1..64, is an elaboration-time error.

Optional Feature:
- Macro: MAJ_COUNT_OUT_EN.
- Defined:
  - Adds output port `ones_count`, width $clog2(WIDTH+1), registered alongside out.
  - Updates only on accepted samples, resets to 0.
  - Same one-cycle latency as out.
- Undefined: the port and its register are absent; out/out_valid behaviour is identical.

Decomposition:
- Shared package majority_pkg:
  - function cnt_w(width) returning $clog2(width+1).
  - localparam DEFAULT_WIDTH=7.
  - typedef for the count type, parameterised via cnt_w.
- One sub-module: maj_popcount.
  - Parameter WIDTH; purely combinational.
  - Input vec[WIDTH-1:0], output cnt[cnt_w(WIDTH)-1:0].
  - Adder tree or loop.
- Top holds the threshold compare, the registers and the valid pipeline.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out=1 → out=0 and out_valid=0 immediately, without waiting for a clock edge.
- Directed vector sequence, WIDTH=7, in_valid=1 every cycle; out follows one cycle later with out_valid=1 each cycle:
  - 7'd99 (4 ones) → 1
  - 7'd28 (3 ones) → 0
  - 7'd119 (6 ones) → 1
  - 7'd101 (4 ones) → 1
  - 7'd32 (1 one) → 0
  - 7'd48 (2 ones) → 0
  - 7'd75 (4 ones) → 1
- Threshold boundary:
  - 7'b0000111 → 0, 7'b0001111 → 1.
  - 7'h00 → 0, 7'h7F → 1.
- Hold: in_valid=0 while `in` changes to 7'h7F after a 0 result → out stays 0, out_valid=0.
- Parameter sweep:
  - WIDTH=8 default: 8'h0F → 0 (tie), 8'h1F → 1.
  - WIDTH=7, THRESHOLD=2: 7'b0000011 → 1.
- With MAJ_COUNT_OUT_EN: 7'd119 → ones_count=6 alongside out=1, same cycle.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared definitions for the majority voter.
// - cnt_w(width): bit width needed to hold a population count of 0..width.
// - DEFAULT_WIDTH: default number of voting inputs.
// - count_t: count type sized for the default width.
package majority_pkg;

  localparam int DEFAULT_WIDTH = 7;

  // Width of a counter able to represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef logic [cnt_w(DEFAULT_WIDTH)-1:0] count_t;

endpackage

// File: rtl/maj_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Ports:
//   vec  input  [WIDTH-1:0]          vector to count
//   cnt  output [cnt_w(WIDTH)-1:0]   number of ones in vec
module maj_popcount
  import majority_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]        vec,
  output logic [cnt_w(WIDTH)-1:0] cnt
);

  localparam int CW = cnt_w(WIDTH);

  // Simple accumulate loop; synthesis folds this into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/majority_input.sv
// Registered N-input majority voter with a fixed one-cycle latency.
// A sample is taken on each rising clk edge where in_valid=1; out is high
// when the number of ones in `in` is at least THRESHOLD.
// Optional feature (macro MAJ_COUNT_OUT_EN): adds a registered ones_count
// output that updates alongside out.
// Ports:
//   clk         input   rising-edge clock
//   rst_n       input   asynchronous active-low reset
//   in_valid    input   qualifies `in`
//   in          input   [WIDTH-1:0] vote vector, bit i is voter i
//   out         output  registered majority result (holds when idle)
//   out_valid   output  one-cycle pulse after each accepted sample
//   ones_count  output  [cnt_w(WIDTH)-1:0] registered count (MAJ_COUNT_OUT_EN only)
module majority_input
  import majority_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int THRESHOLD = (WIDTH / 2) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             out_valid
`ifdef MAJ_COUNT_OUT_EN
  ,
  output logic [cnt_w(WIDTH)-1:0] ones_count
`endif
);

  localparam int CW = cnt_w(WIDTH);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("majority_input: WIDTH must be within 1..64");
  end
  if (THRESHOLD < 1 || THRESHOLD > WIDTH) begin : g_bad_threshold
    $error("majority_input: THRESHOLD must be within 1..WIDTH");
  end

  // THRESHOLD <= WIDTH always fits in the count width.
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  logic [CW-1:0] count;
  logic          vote;

  maj_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .vec (in),
    .cnt (count)
  );

  // Threshold compare on the current sample.
  always_comb begin
    vote = (count >= THR);
  end

  // Result and valid registers; out only moves on accepted samples, so
  // unknown inputs while idle never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= vote;
      out_valid <= 1'b1;
    end else begin
      out       <= out;
      out_valid <= 1'b0;
    end
  end

`ifdef MAJ_COUNT_OUT_EN
  // Count register, captured with the same qualifier as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_count <= '0;
    end else if (in_valid) begin
      ones_count <= count;
    end else begin
      ones_count <= ones_count;
    end
  end
`endif

endmodule

// File: tb/tb_majority_input.sv
// Self-checking bench for majority_input: randomized stimulus against a
// behavioural model plus directed literal vectors.
module tb_majority_input;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] in_vec;
  logic       out;
  logic       out_valid;

  logic       v8;
  logic [7:0] in8;
  logic       out8, out_valid8;
  logic       v72;
  logic [6:0] in72;
  logic       out72, out_valid72;
`ifdef MAJ_COUNT_OUT_EN
  logic [2:0] ones_count;
  logic [3:0] ones_count8;
  logic [2:0] ones_count72;
`endif

  int compared = 0;
  int mismatched = 0;

  // Model state: what the outputs must be, derived from accepted samples.
  logic       exp_out, exp_valid;
  int         exp_cnt;
  logic       cur_has_lit, cur_lit;
  logic       exp_has_lit, exp_lit;

  majority_input u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_vec),
    .out(out), .out_valid(out_valid)
`ifdef MAJ_COUNT_OUT_EN
    , .ones_count(ones_count)
`endif
  );

  majority_input #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in(in8),
    .out(out8), .out_valid(out_valid8)
`ifdef MAJ_COUNT_OUT_EN
    , .ones_count(ones_count8)
`endif
  );

  majority_input #(.WIDTH(7), .THRESHOLD(2)) u_t2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v72), .in(in72),
    .out(out72), .out_valid(out_valid72)
`ifdef MAJ_COUNT_OUT_EN
    , .ones_count(ones_count72)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: majority means at least 4 of 7 ones.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out <= 1'b0; exp_valid <= 1'b0; exp_cnt <= 0;
      exp_has_lit <= 1'b0; exp_lit <= 1'b0;
    end else if (in_valid === 1'b1) begin
      exp_out     <= ($countones(in_vec) >= 4);
      exp_cnt     <= $countones(in_vec);
      exp_valid   <= 1'b1;
      exp_has_lit <= cur_has_lit;
      exp_lit     <= cur_lit;
    end else begin
      exp_valid   <= 1'b0;
      exp_has_lit <= 1'b0;
    end
  end

  // Single compare process, on the falling edge away from capture.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("out", {31'd0, out}, {31'd0, exp_out});
      if (exp_valid && exp_has_lit)
        check("out_literal", {31'd0, out}, {31'd0, exp_lit});
`ifdef MAJ_COUNT_OUT_EN
      check("ones_count", {29'd0, ones_count}, exp_cnt);
`endif
    end
  end

  task automatic drive(input logic v, input logic [6:0] d, input logic hl, input logic lit);
    @(posedge clk); #2;
    in_valid = v; in_vec = d; cur_has_lit = hl; cur_lit = lit;
  endtask

  logic [6:0] dir_vec [7];
  logic       dir_exp [7];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 7'd0;
    cur_has_lit = 1'b0; cur_lit = 1'b0;
    v8 = 1'b0; in8 = 8'd0; v72 = 1'b0; in72 = 7'd0;

    #3;
    check("reset_out", {31'd0, out}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    #9 rst_n = 1'b1;

    // Directed sequence, back-to-back.
    dir_vec = '{7'd99, 7'd28, 7'd119, 7'd101, 7'd32, 7'd48, 7'd75};
    dir_exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) drive(1'b1, dir_vec[i], 1'b1, dir_exp[i]);

`ifdef MAJ_COUNT_OUT_EN
    drive(1'b1, 7'd119, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("count_119", {29'd0, ones_count}, 32'd6);
    check("out_119", {31'd0, out}, 32'd1);
`endif

    // Threshold boundaries.
    drive(1'b1, 7'b0000111, 1'b1, 1'b0);
    drive(1'b1, 7'b0001111, 1'b1, 1'b1);
    drive(1'b1, 7'h7F, 1'b1, 1'b1);
    drive(1'b1, 7'h00, 1'b1, 1'b0);

    // Hold: idle with all ones (then unknowns) on the bus after a 0 result.
    drive(1'b0, 7'h7F, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold_out", {31'd0, out}, 32'd0);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    in_vec = 7'bxxxxxxx;
    @(posedge clk); #1;
    check("hold_x_out", {31'd0, out}, 32'd0);

    // Reset mid-stream with out=1 and a sample pending.
    drive(1'b1, 7'h7F, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_out", {31'd0, out}, 32'd1);
    in_vec = 7'h7E;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {31'd0, out}, 32'd0);
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("in_reset_valid", {31'd0, out_valid}, 32'd0);
    #1 rst_n = 1'b1;

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, 7'($urandom), 1'b0, 1'b0);
      if (!v && $urandom_range(0, 1) == 1) in_vec = 7'bxxxxxxx;
    end
    drive(1'b0, 7'd0, 1'b0, 1'b0);

    // Parameter sweep: WIDTH=8 tie and majority, THRESHOLD=2.
    @(posedge clk); #2; v8 = 1'b1; in8 = 8'h0F;
    @(posedge clk); #1;
    check("w8_tie", {31'd0, out8}, 32'd0);
    check("w8_tie_valid", {31'd0, out_valid8}, 32'd1);
    #1; in8 = 8'h1F;
    @(posedge clk); #1;
    check("w8_major", {31'd0, out8}, 32'd1);
    #1; v8 = 1'b0;
    @(posedge clk); #1;
    check("w8_idle_valid", {31'd0, out_valid8}, 32'd0);
    #1; v72 = 1'b1; in72 = 7'b0000011;
    @(posedge clk); #1;
    check("t2_two", {31'd0, out72}, 32'd1);
    #1; in72 = 7'b0000100;
    @(posedge clk); #1;
    check("t2_one", {31'd0, out72}, 32'd0);
    #1; v72 = 1'b0;

    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
